// File: rtl/alu_seq_if.sv
// Operand/result bus for alu_seq: start strobe, operands and opcode in; registered result, flags and status out.
interface alu_seq_if #(
  parameter int N = 8
) ();
  logic         start;
  logic [3:0]   func;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [3:0]   flags;

  modport master (
    output start, func, a, b,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, func, a, b,
    output busy, done, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Registered picoMIPS ALU: single-cycle logic/arith/shift ops, optional shift-add multiplier.
// Define ALU_MUL_EN to build the multi-cycle MUL path; otherwise func 11 acts as RA.
module alu_seq #(
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      nReset,
  alu_seq_if.slave  bus
);
  localparam int SW = $clog2(N);

  typedef enum logic [3:0] {
    OP_RA  = 4'd0,
    OP_RB  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ASR = 4'd10,
    OP_MUL = 4'd11
  } op_t;

  logic [SW-1:0] sh;
  logic [N:0]    sum;
  logic [N:0]    diff;
  logic [N:0]    shl_w;
  logic [N:0]    shr_w;
  logic [N:0]    asr_w;
  logic [N-1:0]  res_c;
  logic          c_c;
  logic          v_c;
  logic [3:0]    flags_c;

  logic          done_r;
  logic [N-1:0]  result_r;
  logic [3:0]    flags_r;

  // Shifts run on an (N+1)-bit window so the last bit shifted out lands in a fixed position.
  always_comb begin
    sh    = bus.b[SW-1:0];
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    diff  = {1'b0, bus.a} - {1'b0, bus.b};
    shl_w = {1'b0, bus.a} << sh;
    shr_w = {bus.a, 1'b0} >> sh;
    asr_w = $signed({bus.a, 1'b0}) >>> sh;
    res_c = bus.a;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (bus.func)
      OP_RB:  res_c = bus.b;
      OP_ADD: begin
        res_c = sum[N-1:0];
        c_c   = sum[N];
        v_c   = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        res_c = diff[N-1:0];
        c_c   = ~diff[N];
        v_c   = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
      end
      OP_AND: res_c = bus.a & bus.b;
      OP_OR:  res_c = bus.a | bus.b;
      OP_XOR: res_c = bus.a ^ bus.b;
      OP_NOR: res_c = ~(bus.a | bus.b);
      OP_SHL: begin
        res_c = shl_w[N-1:0];
        c_c   = shl_w[N];
      end
      OP_SHR: begin
        res_c = shr_w[N:1];
        c_c   = shr_w[0];
      end
      OP_ASR: begin
        res_c = asr_w[N:1];
        c_c   = asr_w[0];
      end
      default: res_c = bus.a;
    endcase
    flags_c = {c_c, v_c, res_c[N-1], ~|res_c};
  end

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  state_t          state;
  logic            busy_r;
  logic [SW-1:0]   cnt;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  acc_step;

  always_comb begin
    acc_step = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state    <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      flags_r  <= '0;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.func == OP_MUL) begin
              mcand  <= {{N{1'b0}}, bus.a};
              mplier <= bus.b;
              acc    <= '0;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= MUL;
            end else begin
              result_r <= res_c;
              flags_r  <= flags_c;
              done_r   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // The final step's sum is written straight to the outputs, not via acc.
          if (cnt == SW'(N - 1)) begin
            result_r <= acc_step[N-1:0];
            flags_r  <= {1'b0, |acc_step[2*N-1:N], acc_step[N-1], ~|acc_step[N-1:0]};
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
`else
  always_ff @(posedge clk) begin
    if (!nReset) begin
      done_r   <= 1'b0;
      result_r <= '0;
      flags_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.start) begin
        result_r <= res_c;
        flags_r  <= flags_c;
        done_r   <= 1'b1;
      end
    end
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.flags  = flags_r;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (N=8): directed vectors checked against an arithmetic reference model every cycle.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int N = 8;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.N(N)) bus ();
  alu_seq #(.N(N)) dut (.clk(clk), .nReset(nReset), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model timeline: cycle index = value of cyc after the edge that produced that cycle.
  int         done_at = -1;
  int         busy_from = -1;
  int         busy_to = -1;
  int         clr_at = -1;
  bit         checking = 1'b0;
  logic [7:0] pend_r;
  logic [3:0] pend_fl;
  logic [7:0] hold_r;
  logic [3:0] hold_fl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic [3:0] fl, output int lat);
    int ua, ub, sa, sb, t, n;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    n = ub % 8;
    c = 1'b0; v = 1'b0; lat = 0; t = ua;
    case (f)
      4'd1: t = ub;
      4'd2: begin t = ua + ub; c = t > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      4'd3: begin t = ua - ub; c = ua >= ub; v = (sa - sb > 127) || (sa - sb < -128); end
      4'd4: t = ua & ub;
      4'd5: t = ua | ub;
      4'd6: t = ua ^ ub;
      4'd7: t = ~(ua | ub);
      4'd8: begin t = ua << n; c = (n != 0) && (((ua >> (8 - n)) & 1) != 0); end
      4'd9: begin t = ua >> n; c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
      4'd10: begin t = sa >>> n; c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
`ifdef ALU_MUL_EN
      4'd11: begin t = ua * ub; v = t > 255; lat = N; end
`endif
      default: t = ua;
    endcase
    r = t[7:0];
    fl = {c, v, r[7], r == 8'd0};
  endfunction

  always @(negedge clk) begin : cmp
    logic wd;
    if (checking) begin
      if (cyc == clr_at) begin
        hold_r = '0;
        hold_fl = '0;
      end
      wd = (cyc == done_at);
      if (wd) begin
        hold_r = pend_r;
        hold_fl = pend_fl;
      end
      chk("done", 32'(bus.done), 32'(wd));
      chk("busy", 32'(bus.busy), 32'(cyc >= busy_from && cyc < busy_to));
      chk("result", 32'(bus.result), 32'(hold_r));
      chk("flags", 32'(bus.flags), 32'(hold_fl));
    end
  end

  task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] fl;
    int lat, e;
    @(negedge clk);
    bus.start = 1'b1; bus.func = f; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    e = cyc;
    if (!((e - 1) >= busy_from && (e - 1) < busy_to)) begin
      model(f, a, b, r, fl, lat);
      pend_r = r;
      pend_fl = fl;
      done_at = e + lat;
      if (lat > 0) begin
        busy_from = e;
        busy_to = e + lat;
      end
    end
    // Scramble inputs after capture; an operation in flight must not see them.
    bus.start = 1'b0; bus.func = ~f; bus.a = ~a; bus.b = b ^ 8'h5A;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin(input string nm, input logic [7:0] r, input logic [3:0] fl);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.done !== 1'b1 && k < 40);
    chk({nm, "_done"}, 32'(bus.done), 32'd1);
    chk({nm, "_r"}, 32'(bus.result), 32'(r));
    chk({nm, "_f"}, 32'(bus.flags), 32'(fl));
  endtask

  task automatic do_reset();
    @(negedge clk);
    nReset = 1'b0;
    @(posedge clk);
    #1;
    clr_at = cyc;
    done_at = -1;
    busy_from = -1;
    busy_to = -1;
    nReset = 1'b1;
  endtask

  logic [3:0] tf [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                          4'd8, 4'd9, 4'd10, 4'd12, 4'd2, 4'd3, 4'd11, 4'd15};
  logic [7:0] ta [16] = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'hF0, 8'hA0, 8'hAA, 8'h0F,
                          8'h01, 8'h80, 8'h7F, 8'hC3, 8'h80, 8'h7F, 8'h07, 8'h99};
  logic [7:0] tb [16] = '{8'h56, 8'h78, 8'h01, 8'h01, 8'h3C, 8'h05, 8'hAA, 8'h10,
                          8'h07, 8'h07, 8'h02, 8'h11, 8'h80, 8'hFF, 8'h09, 8'h00};

  initial begin
    bus.start = 1'b0; bus.func = '0; bus.a = '0; bus.b = '0;
    nReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr_at = cyc;
    checking = 1'b1;
    nReset = 1'b1;
    idle(2);

    issue(4'd2, 8'h7F, 8'h01);  pin("add_ovf", 8'h80, 4'b0110);
    issue(4'd3, 8'h05, 8'h05);  pin("sub_zero", 8'h00, 4'b1001);
    issue(4'd3, 8'h80, 8'h01);  pin("sub_ovf", 8'h7F, 4'b1100);
    issue(4'd10, 8'h80, 8'h03); pin("asr", 8'hF0, 4'b0010);
    issue(4'd9, 8'h81, 8'h01);  pin("shr", 8'h40, 4'b1000);
    issue(4'd8, 8'h81, 8'h00);  pin("shl0", 8'h81, 4'b0010);

    for (int i = 0; i < 16; i++) issue(tf[i], ta[i], tb[i]);
    idle(N + 2);

`ifdef ALU_MUL_EN
    issue(4'd11, 8'h0C, 8'h0B); pin("mul", 8'h84, 4'b0010);
    issue(4'd11, 8'h10, 8'h10); pin("mul_ovf", 8'h00, 4'b0101);
    issue(4'd11, 8'h0C, 8'h0B);
    idle(2);
    issue(4'd11, 8'hFF, 8'hFF);
    pin("mul_ign", 8'h84, 4'b0010);
    idle(3);
    issue(4'd11, 8'h03, 8'h05);
    idle(N);
    issue(4'd2, 8'h40, 8'h40);
    idle(3);
`else
    issue(4'd11, 8'h3C, 8'h00); pin("mul_off", 8'h3C, 4'b0000);
`endif

    issue(4'd11, 8'h0C, 8'h0B);
    idle(3);
    do_reset();
    idle(N + 4);

    issue(4'd6, 8'hA5, 8'hFF); pin("post_rst", 8'h5A, 4'b0000);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the picoMIPS 8-function ALU. It accepts an operation on a start strobe and returns a registered result plus a C,V,N,Z flag vector with a done pulse. Logic, add/sub and shift operations complete in one cycle. An optional shift-add multiplier takes N cycles, with busy asserted throughout. It sits between the register file read ports and the write-back/flag register of the picoMIPS datapath.

## Interface
- N, 8: operand/result width in bits, ≥ 4.
- SW, $clog2(N): shift-amount width (derived, not overridden).

- clk  in  1  system clock, rising edge.
- nReset  in  1  synchronous, active-low reset.
- start  in  1  launch operation; sampled only when busy=0.
- func  in  4  operation code (below).
- a  in  N  operand A.
- b  in  N  operand B; low SW bits are the shift amount.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: result/flags valid and updated.
- result  out  N  registered result, held until next done.
- flags  out  4  registered {C,V,N,Z}, held until next done.

## Operation
- func codes:
  - 0 RA: a. 1 RB: b. 2 ADD: a+b. 3 SUB: a-b. 4 AND. 5 OR. 6 XOR. 7 NOR.
  - 8 SHL, 9 SHR (logical), 10 ASR: a shifted by b[SW-1:0].
  - 11 MUL: low N bits of unsigned a*b.
  - 12–15 reserved: behave as RA.
- a, b and func are captured on the accepted start edge. Later input changes do not affect an operation in flight.
- N = result[N-1]. Z = (result == 0), for every op.
- V flag:
  - ADD: signed overflow (operand sign bits equal, result sign differs).
  - SUB: set when a and b signs differ and result sign ≠ a sign.
  - MUL: set when upper N bits of the 2N-bit product ≠ 0.
  - All other ops: 0.
- C flag:
  - ADD: carry out of bit N-1.
  - SUB: 1 when a ≥ b unsigned (no borrow).
  - Shifts: last bit shifted out; 0 when shift amount = 0.
  - All other ops: 0.
- FSM states: IDLE, MUL.
  - IDLE with start and func≠MUL: compute; register result/flags; done=1 next cycle; stay IDLE.
  - IDLE with start and func=MUL: load multiplicand, multiplier and a 2N-bit accumulator; go to MUL.
  - MUL: one shift-add step per cycle over a counter 0..N-1. After the step with count N-1, write result/flags, pulse done and return to IDLE.
- start while busy=1 is ignored; it is not queued.

## Timing
- Reset (nReset=0 at a clk edge): state IDLE; busy=0, done=0, result=0, flags=0, counter=0.
- Reset mid-MUL aborts the operation. No done pulse follows.
- Single-cycle ops: start at edge k gives done=1 with new result/flags after edge k+1. done is high for one cycle only.
- MUL: start at edge k.
  - busy=1 after edges k+1 … k+N.
  - done=1 with result after edge k+N+1, and busy=0 in that same cycle.
- Back-to-back: start may be asserted in the same cycle done is high. It is accepted because busy=0.
- Outputs change only on a done cycle or on reset.

## Configuration
- ALU_MUL_EN defined: MUL state, counter and accumulator are built; MUL behaves as above.
- ALU_MUL_EN undefined: no multiplier logic. func 11 behaves as RA in one cycle, and busy is tied to 0.

## Test plan
- N=8, ADD a=0x7F b=0x01 → done after 1 cycle; result=0x80, flags C=0 V=1 N=1 Z=0.
- SUB a=0x05 b=0x05 → result=0x00, C=1 V=0 N=0 Z=1.
- SUB a=0x80 b=0x01 → result=0x7F, C=1 V=1.
- Shifts:
  - ASR a=0x80 b=3 → 0xF0, C=0, N=1.
  - SHR a=0x81 b=1 → 0x40, C=1.
  - SHL a=0x81 b=0 → 0x81, C=0.
- MUL with ALU_MUL_EN:
  - a=0x0C b=0x0B → busy high 8 cycles; done on cycle 9 after start; result=0x84, V=0.
  - a=0x10 b=0x10 → result=0x00, V=1, Z=1.
  - A second start during busy is ignored: exactly one done, and result is unchanged by the ignored operands.
- Reset and macro-off:
  - Assert nReset=0 at cycle 4 of a MUL → all outputs 0 next cycle and no done thereafter.
  - Without ALU_MUL_EN: func=11 a=0x3C → done after 1 cycle, result=0x3C, busy never high.
